// File: rtl/imm_encoder.sv
// RV32I immediate encoder and instruction packer with a 2-entry output FIFO.
// Optional range checking is enabled by IMM_ENCODER_RANGE_CHECK_EN.
module imm_encoder #(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE = '0,
  parameter int ERR_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_fmt,
  input  logic [INSTR_WIDTH-1:0] in_base,
  input  logic [31:0]            in_imm,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_word,
  output logic [ADDR_WIDTH-1:0]  out_addr,
  output logic                   err_pulse,
  output logic [ERR_WIDTH-1:0]   err_count,
  output logic                   done
);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DRAIN, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [INSTR_WIDTH-1:0] wbuf_q [2];
  logic [ADDR_WIDTH-1:0]  abuf_q [2];
  logic                   rd_q, wr_q;
  logic [1:0]             cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q;

  logic [INSTR_WIDTH-1:0] word;
  logic imm_bad;
  logic accept, push, pop, start_ok;

  always_comb begin
    word = in_base;
    unique case (in_fmt)
      2'd0: word[31:20] = in_imm[11:0];
      2'd1: begin
        word[31:25] = in_imm[11:5];
        word[11:7]  = in_imm[4:0];
      end
      2'd2: begin
        word[31]    = in_imm[12];
        word[7]     = in_imm[11];
        word[30:25] = in_imm[10:5];
        word[11:8]  = in_imm[4:1];
      end
      default: word[31:12] = in_imm[31:12];
    endcase
  end

`ifdef IMM_ENCODER_RANGE_CHECK_EN
  // In range when all bits above the field's sign bit match it.
  always_comb begin
    imm_bad = 1'b0;
    unique case (in_fmt)
      2'd0, 2'd1:
        imm_bad = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      2'd2:
        imm_bad = !((&in_imm[31:12]) || !(|in_imm[31:12]))
                  || in_imm[0];
      default:
        imm_bad = |in_imm[11:0];
    endcase
  end
`else
  assign imm_bad = 1'b0;
`endif

  assign start_ok = start &&
    (state_q == S_IDLE || state_q == S_DONE);
  assign in_ready  = (state_q == S_RUN) && (cnt_q != 2'd2);
  assign accept    = in_valid && in_ready;
  assign push      = accept && !imm_bad;
  assign out_valid = (cnt_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};
  assign out_word  = out_valid ? wbuf_q[rd_q] : '0;
  assign out_addr  = out_valid ? abuf_q[rd_q] : '0;
  assign done      = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (accept && in_last) state_d = S_DRAIN;
      S_DRAIN: if (cnt_d == 2'd0) state_d = S_DONE;
      default: if (start) state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= 2'd0;
      addr_q  <= ADDR_BASE;
      for (int i = 0; i < 2; i++) begin
        wbuf_q[i] <= '0;
        abuf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (push) begin
        wbuf_q[wr_q] <= word;
        abuf_q[wr_q] <= addr_q;
        wr_q <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      if (start_ok) addr_q <= ADDR_BASE;
      else if (push) addr_q <= addr_q + ADDR_WIDTH'(4);
    end
  end

`ifdef IMM_ENCODER_RANGE_CHECK_EN
  logic                 err_q;
  logic [ERR_WIDTH-1:0] errc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= 1'b0;
      errc_q <= '0;
    end else begin
      err_q <= accept && imm_bad;
      if (start_ok) errc_q <= '0;
      else if (accept && imm_bad && !(&errc_q))
        errc_q <= errc_q + 1'b1;
    end
  end

  assign err_pulse = err_q;
  assign err_count = errc_q;
`else
  assign err_pulse = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: directed vectors, queued expectations,
// independent output monitor.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last, out_ready;
  logic [1:0]  in_fmt;
  logic [31:0] in_base, in_imm;
  logic        in_ready, out_valid, err_pulse, done;
  logic [31:0] out_word, out_addr;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  logic [63:0] q[$];
  logic [31:0] exp_addr = 0;

  always #5 clk = ~clk;

  imm_encoder dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_base(in_base),
    .in_imm(in_imm), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_addr(out_addr),
    .err_pulse(err_pulse), .err_count(err_count),
    .done(done)
  );

  logic        held = 1'b0;
  logic [31:0] hw, ha;
  logic [63:0] e;

  always @(negedge clk) begin
    if (rst) begin
      held <= 1'b0;
    end else begin
      if (held && out_valid) begin
        checks++;
        if (out_word !== hw || out_addr !== ha) begin
          errors++;
          $display("FAIL hold: got %h@%h want %h@%h",
                   out_word, out_addr, hw, ha);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected: got %h@%h want none",
                   out_word, out_addr);
        end else begin
          e = q.pop_front();
          if (out_word !== e[63:32] || out_addr !== e[31:0]) begin
            errors++;
            $display("FAIL pop: got %h@%h want %h@%h",
                     out_word, out_addr, e[63:32], e[31:0]);
          end
        end
      end
      held <= out_valid && !out_ready;
      hw   <= out_word;
      ha   <= out_addr;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] f,
                      input logic [31:0] b,
                      input logic [31:0] imm,
                      input logic l,
                      input bit good,
                      input logic [31:0] w);
    int n = 0;
    in_fmt = f; in_base = b; in_imm = imm;
    in_last = l; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: got in_ready 0 want 1");
    end else if (good) begin
      q.push_back({w, exp_addr});
      exp_addr += 4;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done", {31'd0, done}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_last = 1'b0; out_ready = 1'b1;
    in_fmt = 2'd0; in_base = '0; in_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err_pulse", {31'd0, err_pulse}, 0);
    chk("rst_out_word", out_word, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_err_count", {24'd0, err_count}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", {31'd0, in_ready}, 0);

    pulse_start();
    exp_addr = 0;
    chk("run_in_ready", {31'd0, in_ready}, 1);

    send(2'd0, 32'h00000093, 32'hFFFFFFFF, 0, 1, 32'hFFF00093);
    chk("latency", {31'd0, out_valid}, 1);
    send(2'd1, 32'h00002023, 32'h000007FF, 0, 1, 32'h7E002FA3);
    send(2'd2, 32'h00000063, 32'hFFFFFFFC, 0, 1, 32'hFE000EE3);
    send(2'd3, 32'h00000037, 32'h12345000, 0, 1, 32'h12345037);

    pulse_start();

`ifdef IMM_ENCODER_RANGE_CHECK_EN
    send(2'd0, 32'h00000093, 32'd2048, 0, 0, 0);
    chk("err_pulse1", {31'd0, err_pulse}, 1);
    send(2'd2, 32'h00000063, 32'd3, 0, 0, 0);
    chk("err_pulse2", {31'd0, err_pulse}, 1);
    chk("err_count2", {24'd0, err_count}, 2);
    @(posedge clk); #1;
    chk("err_pulse_clr", {31'd0, err_pulse}, 0);
`else
    send(2'd0, 32'h00000093, 32'd2048, 0, 1, 32'h80000093);
    chk("err_pulse_tied", {31'd0, err_pulse}, 0);
    send(2'd2, 32'h00000063, 32'd3, 0, 1, 32'h00000163);
    chk("err_count_tied", {24'd0, err_count}, 0);
`endif
    send(2'd0, 32'h00000013, 32'd5, 1, 1, 32'h00500013);
    wait_done();
    chk("done_in_ready", {31'd0, in_ready}, 0);

    pulse_start();
    exp_addr = 0;
    chk("restart_done", {31'd0, done}, 0);
    chk("restart_err_count", {24'd0, err_count}, 0);
    out_ready = 1'b0;
    send(2'd0, 32'h00000093, 32'd1, 0, 1, 32'h00100093);
    send(2'd0, 32'h00000093, 32'd2, 0, 1, 32'h00200093);
    in_fmt = 2'd0; in_base = 32'h00000093;
    in_imm = 32'd3; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("full_in_ready", {31'd0, in_ready}, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'd0, 32'h00000093, 32'd3, 1, 1, 32'h00300093);
    wait_done();
    chk("drained", q.size(), 0);

    pulse_start();
    exp_addr = 0;
    out_ready = 1'b0;
    send(2'd0, 32'h00000093, 32'd7, 0, 0, 0);
    chk("rerun_valid", {31'd0, out_valid}, 1);
    chk("rerun_addr", out_addr, 0);
    chk("rerun_word", out_word, 32'h00700093);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_out_valid", {31'd0, out_valid}, 0);
    chk("abort_in_ready", {31'd0, in_ready}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_out_word", out_word, 0);
    chk("abort_out_addr", out_addr, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_stays_idle", {31'd0, in_ready | out_valid}, 0);
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
Immediate encoder and instruction-word packer. It is the write-side counterpart of the decode-stage immediate extractor: it scatters a signed immediate into the RV32I bit positions for the I, S, B or U format. Each request arrives as a base instruction plus an immediate over a valid/ready handshake. Packed words leave through a 2-entry output buffer, each tagged with a sequential instruction-memory byte address, and feed the instruction-memory loader and program-generation testbenches.

Parameters:
INSTR_WIDTH, 32, instruction word width; only 32 is supported.
ADDR_WIDTH, 32, width of out_addr.
ADDR_BASE, 0, first byte address issued after start.
ERR_WIDTH, 8, width of the saturating error counter.

Ports:
clk  input  1  clock; all logic is rising-edge.
rst  input  1  synchronous reset, active-high.
start  input  1  one-cycle pulse that begins a program. Honoured in IDLE or DONE only.
in_valid  input  1  request valid.
in_ready  output  1  request accepted when in_valid && in_ready.
in_fmt  input  2  0=I, 1=S, 2=B, 3=U.
in_base  input  INSTR_WIDTH  opcode/rd/rs1/rs2/funct bits; its immediate-field bits are overwritten.
in_imm  input  32  signed immediate, byte offset for B.
in_last  input  1  marks the final request of the program.
out_valid  output  1  packed word available.
out_ready  input  1  consumer ready.
out_word  output  INSTR_WIDTH  packed instruction.
out_addr  output  ADDR_WIDTH  byte address of out_word.
err_pulse  output  1  one-cycle flag for a rejected request.
err_count  output  ERR_WIDTH  count of rejected requests; saturates at all-ones.
done  output  1  high in DONE.

Behaviour:
- Reset values:
  - state=IDLE; buffer empty.
  - in_ready, out_valid, done and err_pulse are 0.
  - out_word, out_addr and err_count are 0.
  - Internal address counter is ADDR_BASE.
  - rst during any state aborts the program and discards buffered words.
- States:
  - IDLE: start -> RUN. The address counter loads ADDR_BASE and err_count clears.
  - RUN: in_ready = (buffer count < 2). An accepted beat with in_last=1 -> DRAIN.
  - DRAIN: in_ready=0. Move to DONE in the cycle the buffer becomes empty.
  - DONE: done=1, in_ready=0. start -> RUN with the same clears as IDLE.
  - start in RUN or DRAIN is ignored.
- Packing: bits not listed below come from in_base.
  - I: word[31:20]=imm[11:0].
  - S: word[31:25]=imm[11:5]; word[11:7]=imm[4:0].
  - B: word[31]=imm[12]; word[7]=imm[11]; word[30:25]=imm[10:5]; word[11:8]=imm[4:1].
  - U: word[31:12]=imm[31:12].
- Range check, evaluated on the accepted beat:
  - I and S: -2048 <= imm <= 2047.
  - B: -4096 <= imm <= 4094 and imm[0]=0.
  - U: imm[11:0]=0.
- Rejected beat:
  - The beat is consumed and not buffered.
  - err_pulse=1 on the next cycle; err_count increments, saturating.
  - The address counter does not advance.
  - in_last on a rejected beat still moves the FSM to DRAIN.
- Accepted good beat:
  - The word is written into the buffer with the current address.
  - The counter advances by 4 and wraps modulo 2^ADDR_WIDTH.
- Latency: accept in cycle N gives out_valid in N+1 when the buffer was empty.
- Output buffer:
  - FIFO order.
  - out_word and out_addr hold stable while out_valid && !out_ready.
  - A push and a pop in the same cycle leave the count unchanged.
  - in_ready is registered-safe: no push can occur when count=2.

Optional Feature:
IMM_ENCODER_RANGE_CHECK_EN
- Defined: range checks, rejection, err_pulse and err_count behave as above.
- Undefined: no checking. Immediates are truncated into their fields and every beat is buffered. err_pulse and err_count are tied to 0.

Test Plan:
1. start; I, base 0x00000093, imm=-1 -> out_word 0xFFF00093, out_addr 0x0, out_valid one cycle after accept.
2. S, base 0x00002023, imm=0x7FF -> out_word 0x7E002FA3, out_addr 0x4.
3. B, base 0x00000063, imm=-4 -> out_word 0xFE000EE3. U, base 0x00000037, imm=0x12345000 -> out_word 0x12345037.
4. Range-check build:
   - I imm=2048 and B imm=3 -> two err_pulses, err_count=2, no out_valid, next good word keeps the unadvanced address.
   - Repeat without the macro: I imm=2048 -> out_word with bits[31:20]=0x800.
5. Backpressure: out_ready=0, offer 3 I-type beats -> in_ready low after 2 accepted. Raise out_ready -> 3 words in order at addresses 0x0, 0x4, 0x8.
6. Lifecycle:
   - in_last on the 3rd beat -> DRAIN, then done=1 after the last pop. start -> RUN, addr back to ADDR_BASE.
   - rst asserted mid-RUN with 1 word buffered -> out_valid=0 next cycle, state IDLE, all outputs at reset values.
